// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks a hole from the LFSR value, times the up and gap windows from the game tick, and scores hits and misses.
// Optional build macro MOLE_SCHED_SPEEDUP_EN: the up window shrinks as the hit count grows.
module mole_scheduler #(
    parameter int NUM_HOLES = 4,
    parameter int UP_TICKS  = 8,
    parameter int GAP_TICKS = 4,
    parameter int ROUNDS    = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 tick_i,
    input  logic [4:0]           rnd_i,
    input  logic [NUM_HOLES-1:0] whack_i,
    output logic [NUM_HOLES-1:0] mole_o,
    output logic [7:0]           hits_o,
    output logic [7:0]           misses_o,
    output logic                 busy_o,
    output logic                 game_over_o
);

    localparam int IW   = $clog2(NUM_HOLES);
    localparam int TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PICK,
        S_UP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d;
    logic [7:0]           hits_q, hits_d;
    logic [7:0]           misses_q, misses_d;
    logic [7:0]           round_q, round_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [TW-1:0]        uplen_q, uplen_d;
    logic [IW-1:0]        prev_q, prev_d;
    logic [1:0]           retry_q, retry_d;

    logic [IW-1:0]        pick_idx;
    logic                 pick_ok;
    logic                 round_end;
    logic [TW-1:0]        up_len_new;
    logic                 unused_rnd;

    assign unused_rnd = ^rnd_i;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

`ifdef MOLE_SCHED_SPEEDUP_EN
    function automatic logic [TW-1:0] speedup_len(input logic [7:0] h);
        int len;
        len = UP_TICKS - int'(h[7:2]);
        if (len < 2) len = 2;
        return TW'(len);
    endfunction

    assign up_len_new = speedup_len(hits_q);
`else
    assign up_len_new = TW'(UP_TICKS);
`endif

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        round_d   = round_q;
        tick_d    = tick_q;
        uplen_d   = uplen_q;
        prev_d    = prev_q;
        retry_d   = retry_q;
        pick_idx  = rnd_i[IW-1:0];
        pick_ok   = 1'b0;
        round_end = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    hits_d   = 8'd0;
                    misses_d = 8'd0;
                    round_d  = 8'd0;
                    tick_d   = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (tick_i) begin
                    if (tick_q == TW'(GAP_TICKS - 1)) begin
                        tick_d  = '0;
                        retry_d = 2'd0;
                        state_d = S_PICK;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_PICK: begin
                // Avoid showing the same hole twice; after three equal resamples force the neighbour.
                if (pick_idx != prev_q) begin
                    pick_ok = 1'b1;
                end else if (retry_q == 2'd3) begin
                    pick_idx = prev_q + IW'(1);
                    pick_ok  = 1'b1;
                end else begin
                    retry_d = retry_q + 2'd1;
                end
                if (pick_ok) begin
                    mole_d  = {{(NUM_HOLES-1){1'b0}}, 1'b1} << pick_idx;
                    prev_d  = pick_idx;
                    tick_d  = '0;
                    uplen_d = up_len_new;
                    state_d = S_UP;
                end
            end
            S_UP: begin
                // A correct whack takes priority over a concurrent expiring tick.
                if (whack_i[prev_q]) begin
                    hits_d    = sat_inc(hits_q);
                    round_end = 1'b1;
                end else if (tick_i) begin
                    if (tick_q == uplen_q - TW'(1)) begin
                        misses_d  = sat_inc(misses_q);
                        round_end = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                if (round_end) begin
                    mole_d  = '0;
                    round_d = round_q + 8'd1;
                    tick_d  = '0;
                    state_d = (round_q + 8'd1 == 8'(ROUNDS)) ? S_DONE : S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mole_q   <= '0;
            hits_q   <= 8'd0;
            misses_q <= 8'd0;
            round_q  <= 8'd0;
            tick_q   <= '0;
            uplen_q  <= '0;
            prev_q   <= '0;
            retry_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            mole_q   <= mole_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            round_q  <= round_d;
            tick_q   <= tick_d;
            uplen_q  <= uplen_d;
            prev_q   <= prev_d;
            retry_q  <= retry_d;
        end
    end

    assign mole_o      = mole_q;
    assign hits_o      = hits_q;
    assign misses_o    = misses_q;
    assign busy_o      = (state_q == S_GAP) || (state_q == S_PICK) || (state_q == S_UP);
    assign game_over_o = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed game scenarios plus random play, checked every cycle against a round-level reference model.
module tb_mole_scheduler;

    localparam int NH  = 4;
    localparam int UP  = 8;
    localparam int GAP = 4;
    localparam int RND = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          tick;
    logic [4:0]    rnd;
    logic [NH-1:0] whack;
    logic [NH-1:0] mole;
    logic [7:0]    hits;
    logic [7:0]    misses;
    logic          busy;
    logic          game_over;

    mole_scheduler #(
        .NUM_HOLES(NH),
        .UP_TICKS (UP),
        .GAP_TICKS(GAP),
        .ROUNDS   (RND)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .tick_i     (tick),
        .rnd_i      (rnd),
        .whack_i    (whack),
        .mole_o     (mole),
        .hits_o     (hits),
        .misses_o   (misses),
        .busy_o     (busy),
        .game_over_o(game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: game flag, remaining gap ticks, pick attempts, visible hole, remaining up ticks.
    int m_game = 0, m_over = 0, m_gap_left = 0, m_picking = 0, m_tries = 0;
    int m_hole = -1, m_prev = 0, m_up_left = 0;
    int m_hits = 0, m_misses = 0, m_rounds = 0;

    function automatic int up_length(input int h);
        int l;
`ifdef MOLE_SCHED_SPEEDUP_EN
        l = UP - h / 4;
        if (l < 2) l = 2;
`else
        l = UP;
`endif
        return l;
    endfunction

    task automatic show(input int idx);
        m_hole    = idx;
        m_prev    = idx;
        m_picking = 0;
        m_up_left = up_length(m_hits);
    endtask

    task automatic end_round();
        m_hole = -1;
        m_rounds++;
        if (m_rounds == RND) begin
            m_game = 0;
            m_over = 1;
        end else begin
            m_gap_left = GAP;
        end
    endtask

    task automatic model_step();
        int idx;
        if (reset) begin
            m_game = 0; m_over = 0; m_gap_left = 0; m_picking = 0; m_tries = 0;
            m_hole = -1; m_prev = 0; m_up_left = 0;
            m_hits = 0; m_misses = 0; m_rounds = 0;
        end else if (m_game == 0) begin
            if (start) begin
                m_hits = 0; m_misses = 0; m_rounds = 0;
                m_game = 1; m_over = 0; m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            if (tick) begin
                m_gap_left--;
                if (m_gap_left == 0) begin
                    m_picking = 1;
                    m_tries   = 0;
                end
            end
        end else if (m_picking != 0) begin
            idx = int'(rnd) % NH;
            if (idx != m_prev) show(idx);
            else if (m_tries == 3) show((m_prev + 1) % NH);
            else m_tries++;
        end else begin
            if (whack[m_hole]) begin
                if (m_hits < 255) m_hits++;
                end_round();
            end else if (tick) begin
                m_up_left--;
                if (m_up_left == 0) begin
                    if (m_misses < 255) m_misses++;
                    end_round();
                end
            end
        end
    endtask

    task automatic step();
        logic [31:0] exp_mole;
        @(posedge clk);
        model_step();
        #1;
        exp_mole = (m_hole >= 0) ? (32'd1 << m_hole) : 32'd0;
        check("mole", 32'(mole), exp_mole);
        check("hits", 32'(hits), 32'(m_hits));
        check("misses", 32'(misses), 32'(m_misses));
        check("busy", 32'(busy), 32'(m_game));
        check("over", 32'(game_over), 32'(m_over));
    endtask

    task automatic wait_mole(input int period, input int bound);
        int i;
        i = 0;
        while (mole == '0 && i < bound) begin
            tick = (i % period == period - 1);
            rnd  = 5'($urandom);
            step();
            tick = 1'b0;
            i++;
        end
        check("wait_mole", 32'(mole != '0), 32'd1);
    endtask

    task automatic run_no_whack(input int bound);
        int i;
        i = 0;
        while (game_over == 1'b0 && i < bound) begin
            tick = (i % 3 == 0);
            rnd  = 5'($urandom);
            step();
            tick = 1'b0;
            i++;
        end
    endtask

    initial begin
        logic [NH-1:0] saved;
        int lat;
        int r;

        reset = 1'b1; start = 1'b0; tick = 1'b0; rnd = 5'd0; whack = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_mole", 32'(mole), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Forced rnd=1f: first mole lands on hole 3
        rnd = 5'h1f; start = 1'b1;
        step();
        start = 1'b0;
        begin
            int i;
            i = 0;
            while (mole == '0 && i < 200) begin
                tick = (i % 10 == 9);
                step();
                tick = 1'b0;
                i++;
            end
        end
        check("t1_mole", 32'(mole), 32'h8);
        check("t1_busy", 32'(busy), 32'd1);

        // Two up ticks, then a correct whack before the third
        for (int k = 0; k < 2; k++) begin
            tick = 1'b1; step(); tick = 1'b0;
            step(); step(); step();
        end
        whack = 4'b1000;
        step();
        whack = '0;
        check("t2_hits", 32'(hits), 32'd1);
        check("t2_mole", 32'(mole), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);

        // Repeated rnd matching the previous hole: four pick cycles, then the neighbour
        rnd = 5'h03;
        for (int k = 0; k < GAP; k++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (k < GAP - 1) begin step(); step(); end
        end
        lat = 0;
        while (mole == '0 && lat < 20) begin
            step();
            lat++;
        end
        check("t3_lat", 32'(lat), 32'd4);
        check("t3_mole", 32'(mole), 32'h1);

        // Finish this game with no whacks, then a fresh game with no whacks at all
        run_no_whack(5000);
        check("t4a_over", 32'(game_over), 32'd1);
        check("t4a_misses", 32'(misses), 32'(RND - 1));
        start = 1'b1; step(); start = 1'b0;
        check("t4_clear_h", 32'(hits), 32'd0);
        check("t4_clear_m", 32'(misses), 32'd0);
        run_no_whack(5000);
        check("t4_misses", 32'(misses), 32'(RND));
        check("t4_hits", 32'(hits), 32'd0);
        check("t4_over", 32'(game_over), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("t4_restart_m", 32'(misses), 32'd0);
        check("t4_restart_busy", 32'(busy), 32'd1);

        // Wrong-hole whack ignored; correct whack on the expiring tick scores a hit
        wait_mole(3, 300);
        saved = mole;
        whack = ~mole;
        step();
        whack = '0;
        check("t5_wrong_mole", 32'(mole), 32'(saved));
        check("t5_wrong_hits", 32'(hits), 32'd0);
        for (int k = 0; k < UP - 1; k++) begin
            tick = 1'b1; step(); tick = 1'b0;
            step();
        end
        check("t5_still_up", 32'(mole), 32'(saved));
        tick = 1'b1; whack = saved;
        step();
        tick = 1'b0; whack = '0;
        check("t5_hits", 32'(hits), 32'd1);
        check("t5_misses", 32'(misses), 32'd0);
        check("t5_mole", 32'(mole), 32'd0);

        // Reset while a mole is up
        wait_mole(3, 300);
        tick = 1'b1; step(); tick = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check("t6_mole", 32'(mole), 32'd0);
        check("t6_hits", 32'(hits), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Random play
        for (int c = 0; c < 8000; c++) begin
            start = ($urandom_range(0, 49) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            rnd   = 5'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
            r     = int'($urandom_range(0, 7));
            if (r < 2) whack = (m_hole >= 0) ? NH'(1 << m_hole) : '0;
            else if (r == 2) whack = NH'($urandom);
            else whack = '0;
            step();
        end
        start = 1'b0; tick = 1'b0; whack = '0; reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
